// File: rtl/ksa_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
// With KSA_PIPE_FLAGS_EN defined, the beat metadata also carries the sign bits needed for the overflow flag.
package ksa_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  typedef struct packed {
    logic ceff;
`ifdef KSA_PIPE_FLAGS_EN
    logic sub;
    logic a_msb;
    logic b_msb;
`endif
  } meta_t;

  function automatic int levels_f(input int width);
    return $clog2(width);
  endfunction

  function automatic int lat_f(input int levels, input int pipe_every);
    return 32'sd2 + (levels + pipe_every - 32'sd1) / pipe_every
           - (((levels % pipe_every) == 32'sd0) ? 32'sd1 : 32'sd0);
  endfunction

  // A group that ends exactly on the last level shares the output register instead of adding one.
  function automatic bit stage_reg_f(input int lvl, input int levels, input int pipe_every);
    return (((lvl % pipe_every) == 32'sd0) && (lvl < levels)) ||
           ((lvl == levels) && ((levels % pipe_every) != 32'sd0));
  endfunction

endpackage

// File: rtl/ksa_cell.sv
// Kogge-Stone black cell: merges a high group (g,p) with the adjacent lower group.
module ksa_cell
  import ksa_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t o
);

  assign o.g = hi.g | (hi.p & lo.g);
  assign o.p = hi.p & lo.p;

endmodule

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a single global stall (valid/ready on both sides).
// KSA_PIPE_FLAGS_EN adds out_ovf/out_zero and the pipeline bits that feed them.
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int PIPE_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef KSA_PIPE_FLAGS_EN
  ,
  output logic             out_ovf,
  output logic             out_zero
`endif
);

  localparam int LEVELS = levels_f(WIDTH);

  logic             adv_s;
  logic [WIDTH-1:0] beff_s;
  logic [WIDTH-1:0] xp_in_s;
  meta_t            meta_in_s;
  gp_t [WIDTH-1:0]  gp_in_s;

  logic             v0_r;
  meta_t            meta0_r;
  logic [WIDTH-1:0] xp0_r;
  gp_t [WIDTH-1:0]  gp0_r;

  // Index 0 is the input register; index l is the beat after prefix level l.
  logic             v_s    [0:LEVELS];
  meta_t            meta_s [0:LEVELS];
  logic [WIDTH-1:0] xp_s   [0:LEVELS];
  gp_t [WIDTH-1:0]  gp_s   [0:LEVELS];

  logic [WIDTH-1:0] gl_s;
  logic [WIDTH-1:0] sum_s;

  assign adv_s    = ~out_valid | out_ready;
  assign in_ready = adv_s;

  // Operand conditioning and bitwise g/p; the effective carry-in is folded into bit 0's generate.
  always_comb begin
    beff_s         = in_b ^ {WIDTH{in_sub}};
    xp_in_s        = in_a ^ beff_s;
    meta_in_s      = '0;
    meta_in_s.ceff = in_sub | in_cin;
`ifdef KSA_PIPE_FLAGS_EN
    meta_in_s.sub   = in_sub;
    meta_in_s.a_msb = in_a[WIDTH-1];
    meta_in_s.b_msb = in_b[WIDTH-1];
`endif
    for (int i = 0; i < WIDTH; i++) begin
      gp_in_s[i].g = in_a[i] & beff_s[i];
      gp_in_s[i].p = xp_in_s[i];
    end
    gp_in_s[0].g = gp_in_s[0].g | (xp_in_s[0] & meta_in_s.ceff);
  end

  // Input stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_r    <= 1'b0;
      meta0_r <= '0;
      xp0_r   <= '0;
      gp0_r   <= '0;
    end else if (adv_s) begin
      v0_r    <= in_valid;
      meta0_r <= meta_in_s;
      xp0_r   <= xp_in_s;
      gp0_r   <= gp_in_s;
    end
  end

  assign v_s[0]    = v0_r;
  assign meta_s[0] = meta0_r;
  assign xp_s[0]   = xp0_r;
  assign gp_s[0]   = gp0_r;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int SPAN = 32'sd1 << (l - 32'sd1);
    gp_t [WIDTH-1:0] nxt_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_black
        ksa_cell u_cell (
          .hi (gp_s[l-1][i]),
          .lo (gp_s[l-1][i-SPAN]),
          .o  (nxt_s[i])
        );
      end else begin : g_buf
        assign nxt_s[i] = gp_s[l-1][i];
      end
    end

    if (stage_reg_f(l, LEVELS, PIPE_EVERY)) begin : g_reg
      logic             v_r;
      meta_t            meta_r;
      logic [WIDTH-1:0] xp_r;
      gp_t [WIDTH-1:0]  gp_r;

      // Intermediate register closing this group of prefix levels.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_r    <= 1'b0;
          meta_r <= '0;
          xp_r   <= '0;
          gp_r   <= '0;
        end else if (adv_s) begin
          v_r    <= v_s[l-1];
          meta_r <= meta_s[l-1];
          xp_r   <= xp_s[l-1];
          gp_r   <= nxt_s;
        end
      end

      assign v_s[l]    = v_r;
      assign meta_s[l] = meta_r;
      assign xp_s[l]   = xp_r;
      assign gp_s[l]   = gp_r;
    end else begin : g_pass
      assign v_s[l]    = v_s[l-1];
      assign meta_s[l] = meta_s[l-1];
      assign xp_s[l]   = xp_s[l-1];
      assign gp_s[l]   = nxt_s;
    end
  end

  // Final group generates are the carries out of each bit; bit 0 sees the effective carry-in.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      gl_s[i] = gp_s[LEVELS][i].g;
    end
    sum_s = xp_s[LEVELS] ^ {gl_s[WIDTH-2:0], meta_s[LEVELS].ceff};
  end

  // Output register; holds the presented result while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
`ifdef KSA_PIPE_FLAGS_EN
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
`endif
    end else if (adv_s) begin
      out_valid <= v_s[LEVELS];
      out_sum   <= sum_s;
      out_cout  <= gl_s[WIDTH-1];
`ifdef KSA_PIPE_FLAGS_EN
      out_ovf   <= (meta_s[LEVELS].a_msb == (meta_s[LEVELS].b_msb ^ meta_s[LEVELS].sub)) &
                   (sum_s[WIDTH-1] != meta_s[LEVELS].a_msb);
      out_zero  <= (sum_s == '0);
`endif
    end
  end

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Self-checking bench: directed literals, random stalled stream, mid-flight reset, width/pipe sweep.
module tb_ksa_pipe_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  localparam int SW_W   [6] = '{8, 8, 32, 32, 128, 128};
  localparam int SW_P   [6] = '{1, 3, 1, 5, 1, 7};
  localparam int SW_LAT [6] = '{4, 2, 6, 2, 8, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst_n;
  logic        in_valid, in_cin, in_sub, out_ready;
  logic [63:0] in_a, in_b;
  logic        m_in_ready, m_out_valid, m_cout;
  logic [63:0] m_sum;
`ifdef KSA_PIPE_FLAGS_EN
  logic        m_ovf, m_zero;
`endif

  logic         sw_valid, sw_cin, sw_sub, sw_done;
  logic [127:0] sw_a, sw_b;

  exp_t q_main[$];

  ksa_pipe_adder #(.WIDTH(64), .PIPE_EVERY(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (m_in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (m_out_valid),
    .out_ready (out_ready),
    .out_sum   (m_sum),
    .out_cout  (m_cout)
`ifdef KSA_PIPE_FLAGS_EN
    ,
    .out_ovf   (m_ovf),
    .out_zero  (m_zero)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: result stream out of order with expected stream", name);
  endtask

  // {cout,sum} of a + b (or a - b) at width w, as plain wide arithmetic.
  function automatic logic [128:0] ref_add(input logic [127:0] a, input logic [127:0] b,
                                           input logic cin, input logic sub, input int w);
    logic [128:0] mask, am, bm;
    mask = (129'd1 << w) - 129'd1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    if (sub) return am + ((~bm) & mask) + 129'd1;
    else     return am + bm + {128'd0, cin};
  endfunction

  // Signed overflow: the true signed result does not fit in 64 bits.
  function automatic logic ovf64(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
    logic signed [65:0] sa, sb, s;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    s  = sub ? (sa - sb) : (sa + sb + $signed({65'd0, cin}));
    return !((s[65:63] == 3'b000) || (s[65:63] == 3'b111));
  endfunction

  function automatic exp_t model64(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
    exp_t e;
    logic [128:0] r;
    r      = ref_add({64'd0, a}, {64'd0, b}, cin, sub, 64);
    e.sum  = r[63:0];
    e.cout = r[64];
    e.zero = (r[63:0] == 64'd0);
    e.ovf  = ovf64(a, b, cin, sub);
    return e;
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Compare process for the main DUT: in-order scoreboard plus hold-while-stalled check.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_sum;
  logic        prev_cout;
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_out_valid, 1'b1);
        chk("stall_sum", m_sum, prev_sum);
        chk("stall_cout", m_cout, prev_cout);
      end
      if (m_out_valid && out_ready) begin
        if (q_main.size() == 0) fail_now("main_extra_result");
        else begin
          e = q_main.pop_front();
          chk("sum", m_sum, e.sum);
          chk("cout", m_cout, e.cout);
`ifdef KSA_PIPE_FLAGS_EN
          chk("ovf", m_ovf, e.ovf);
          chk("zero", m_zero, e.zero);
`endif
        end
      end
      if (in_valid && m_in_ready) q_main.push_back(model64(in_a, in_b, in_cin, in_sub));
      prev_stall = m_out_valid && !out_ready;
      prev_sum   = m_sum;
      prev_cout  = m_cout;
    end
  end

  // Sweep instances share stimulus; out_ready is held high so every beat has fixed latency.
  for (genvar k = 0; k < 6; k++) begin : g_sw
    localparam int W = SW_W[k];
    logic [W-1:0] sum;
    logic         cout, ovalid, iready;
`ifdef KSA_PIPE_FLAGS_EN
    logic         ovf, zero;
`endif
    logic [W:0]   q_res[$];
    int           q_cyc[$];
    bit           drained = 1'b0;

    ksa_pipe_adder #(.WIDTH(W), .PIPE_EVERY(SW_P[k])) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_valid),
      .in_ready  (iready),
      .in_a      (sw_a[W-1:0]),
      .in_b      (sw_b[W-1:0]),
      .in_cin    (sw_cin),
      .in_sub    (sw_sub),
      .out_valid (ovalid),
      .out_ready (1'b1),
      .out_sum   (sum),
      .out_cout  (cout)
`ifdef KSA_PIPE_FLAGS_EN
      ,
      .out_ovf   (ovf),
      .out_zero  (zero)
`endif
    );

    always @(negedge clk) begin : mon_sw
      logic [128:0] r;
      logic [W:0]   e;
      int           c;
      if (rst_n) begin
        if (ovalid) begin
          if (q_res.size() == 0) fail_now("sweep_extra_result");
          else begin
            e = q_res.pop_front();
            c = q_cyc.pop_front();
            chk("sweep_sum", sum, e[W-1:0]);
            chk("sweep_cout", cout, e[W]);
            chk("sweep_latency", cyc - c, SW_LAT[k]);
          end
        end
        if (sw_valid) begin
          chk("sweep_in_ready", iready, 1'b1);
          r = ref_add(sw_a, sw_b, sw_cin, sw_sub, W);
          q_res.push_back(r[W:0]);
          q_cyc.push_back(cyc);
        end
        if (sw_done && !drained) begin
          drained = 1'b1;
          chk("sweep_drained", q_res.size(), 0);
        end
      end
    end
  end

  task automatic directed(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub,
                          input logic [63:0] es, input logic ec, input logic eo, input logic ez,
                          input string nm);
    int stamp;
    bit got;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; out_ready = 1'b1;
    stamp = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = m_out_valid;
    end
    if (!got) fail_now({nm, "_timeout"});
    else begin
      chk({nm, "_latency"}, cyc - stamp, 4);
      chk({nm, "_sum"}, m_sum, es);
      chk({nm, "_cout"}, m_cout, ec);
`ifdef KSA_PIPE_FLAGS_EN
      chk({nm, "_ovf"}, m_ovf, eo);
      chk({nm, "_zero"}, m_zero, ez);
`endif
    end
  endtask

  initial begin
    int sent;
    rst_n = 1'b0; in_valid = 1'b0; in_a = 64'd0; in_b = 64'd0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0; sw_valid = 1'b0; sw_a = 128'd0; sw_b = 128'd0; sw_cin = 1'b0; sw_sub = 1'b0;
    sw_done = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", m_out_valid, 1'b0);
    chk("rst_in_ready", m_in_ready, 1'b1);
    chk("rst_sum", m_sum, 64'd0);
    chk("rst_cout", m_cout, 1'b0);
`ifdef KSA_PIPE_FLAGS_EN
    chk("rst_ovf", m_ovf, 1'b0);
    chk("rst_zero", m_zero, 1'b0);
`endif
    #3 rst_n = 1'b1;

    directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, "wrap");
    directed(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, "pos_ovf");
    directed(64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_neg");
    directed(64'h1234, 64'h1234, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1, "sub_equal");

    // Random stream with random back-pressure.
    sent = 0;
    while (sent < 120) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = pick64();
      in_b      = pick64();
      in_cin    = 1'($urandom_range(0, 1));
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && m_in_ready) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 40 && q_main.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    chk("stream_drained", q_main.size(), 0);

    // Three beats in flight, result stalled, then a one-cycle reset pulse.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_a = pick64(); in_b = pick64(); in_cin = 1'b0; in_sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("inflight_valid", m_out_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", m_out_valid, 1'b0);
    chk("midrst_in_ready", m_in_ready, 1'b1);
    chk("midrst_sum", m_sum, 64'd0);
    q_main.delete();
    #9 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("no_stale_result", m_out_valid, 1'b0);
    end
    directed(64'd100, 64'd23, 1'b1, 1'b0, 64'd124, 1'b0, 1'b0, 1'b0, "post_reset");

    // Sweep: low byte exhaustive over a,b for the 8-bit instances, random upper bits elsewhere.
    @(posedge clk); #1;
    for (int i = 0; i < 65536; i++) begin
      sw_valid  = 1'b1;
      sw_a      = {$urandom, $urandom, $urandom, $urandom};
      sw_b      = {$urandom, $urandom, $urandom, $urandom};
      sw_a[7:0] = i[7:0];
      sw_b[7:0] = i[15:8];
      sw_sub    = ((i % 3) == 2);
      sw_cin    = ((i % 3) == 1) || (((i % 3) == 2) && ($urandom_range(0, 1) == 1));
      @(posedge clk); #1;
    end
    sw_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 sw_done = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
